divider_stream_adapter: RTL and testbench
=========================================

Name: divider_stream_adapter

Overview:
Valid/ready front-end for divider_nonrestoring_signed. It accepts signed divide requests from a stream, drives the divider's start/operand ports, and waits for done. It then normalises the divider's quotient/remainder pair to SV truncation convention: remainder sign follows numerator, or remainder is zero. Divide-by-zero and MIN/-1 overflow are short-circuited without invoking the divider, and results are presented on a held valid/ready output stream.

Parameters:
WORD_WIDTH, 8, operand/result width in bits (two's complement)
TIMEOUT_CYCLES, 4*WORD_WIDTH+8, WAIT-state watchdog limit; used only with DIV_ADAPTER_TIMEOUT_EN

Ports:
CLK  in  1  clock
ARST  in  1  reset, asynchronous, active-high
CE  in  1  clock enable; all state frozen when low
IN_VALID  in  1  request valid
IN_READY  out  1  request ready
IN_NUM  in  WORD_WIDTH  signed numerator
IN_DEN  in  WORD_WIDTH  signed denominator
DIV_NUM_OUT  out  WORD_WIDTH  to divider NUMERATOR_IN
DIV_DEN_OUT  out  WORD_WIDTH  to divider DENOMINATOR_IN
DIV_START  out  1  to divider start, one-cycle pulse
DIV_QUOT_IN  in  WORD_WIDTH  from divider QUOTENT_OUT
DIV_REM_IN  in  WORD_WIDTH  from divider REMAINDER_OUT
DIV_DONE  in  1  from divider done
OUT_VALID  out  1  result valid
OUT_READY  in  1  result ready
OUT_QUOT  out  WORD_WIDTH  normalised quotient
OUT_REM  out  WORD_WIDTH  normalised remainder
OUT_DIVZERO  out  1  result is for den==0
OUT_OVF  out  1  result is for MIN/-1
OUT_TIMEOUT  out  1  watchdog fired (constant 0 without macro)
BUSY  out  1  state != IDLE

Behaviour:
- ARST high: state=IDLE. All outputs 0, except IN_READY, which follows CE. Operand registers 0. Reset effect is immediate.
- All outputs are registered, except IN_READY = (state==IDLE) & CE.
- States: IDLE, ISSUE, WAIT, FIX, OUT.
- IDLE: handshake at cycle N captures IN_NUM/IN_DEN.
  - den==0: go to OUT at N+1 with q=0, r=num, OUT_DIVZERO=1, no DIV_START.
  - num==MIN and den==-1: go to OUT at N+1 with q=MIN, r=0, OUT_OVF=1, no DIV_START.
  - Otherwise: DIV_NUM_OUT/DIV_DEN_OUT take the operands and go to ISSUE.
- ISSUE (cycle N+1): DIV_START=1 for exactly this cycle; go to WAIT.
- WAIT: completion is a DIV_DONE rising edge (high now, registered-low last enabled cycle). A done level left over from a previous op is ignored. On the edge, capture DIV_QUOT_IN/DIV_REM_IN and go to FIX.
- FIX (one cycle): correction step.
  - Applies when r!=0 and sign(r)!=sign(num).
  - If sign(r)!=sign(den): r+=den, q-=1. Else: r-=den, q+=1.
  - One step suffices because the divider guarantees |r|<|den|. Arithmetic is WORD_WIDTH wrap.
  - Result is registered; go to OUT.
- OUT: OUT_VALID=1. OUT_QUOT/REM and flags are stable until handshake. On OUT_VALID&OUT_READY: go to IDLE, OUT_VALID=0 next cycle, flags cleared.
- Latency: normal path, OUT_VALID = divider-done edge + 2 cycles. Short-circuit, OUT_VALID at N+1.
- No new request is accepted while the result is pending; the adapter is single-outstanding.
- CE low: no state, counter, or edge-detect update; DIV_START holds its value. IN_READY is 0.
- DIV_NUM_OUT/DIV_DEN_OUT are held constant from ISSUE through FIX.
- Reset mid-WAIT: the divider may still finish. Its later done edge is ignored in IDLE.

Optional Feature:
- Macro DIV_ADAPTER_TIMEOUT_EN.
- Defined: a WAIT counter starts at 0 on entry. If it reaches TIMEOUT_CYCLES with no done edge, go to OUT with q=0, r=0, OUT_TIMEOUT=1.
- Undefined: no counter; WAIT waits indefinitely; OUT_TIMEOUT tied 0.

Decomposition:
- Package divider_adapter_pkg: state enum (IDLE, ISSUE, WAIT, FIX, OUT) and a WORD_WIDTH-parameterised MIN constant function.
- Sub-module divider_sign_fix: combinational (num, den, q, r) -> (q', r') correction, instantiated in FIX. It is reusable after other divider variants.

Test Plan:
- 7/2, divider model returns q=4 r=-1 -> DIV_START one pulse; OUT q=3 r=1, flags 0, OUT_VALID at done-edge+2.
- 7/-2, model returns q=-4 r=-1 -> q=-3 r=1. Also -7/2, model returns q=-3 r=-1 -> unchanged q=-3 r=-1.
- 5/0 -> no DIV_START; OUT_VALID at N+1, q=0 r=5 OUT_DIVZERO=1. Also -128/-1 -> q=-128 r=0 OUT_OVF=1, no start.
- Model holds DIV_DONE high from a prior op when START issues, drops it 1 cycle, rises 3 cycles later -> capture only on the rising edge.
- OUT_READY low 5 cycles with IN_VALID high -> IN_READY=0, outputs stable; second op accepted the cycle after handshake. CE low 3 cycles mid-WAIT -> latency extends by 3.
- ARST pulse during WAIT -> outputs 0 immediately, IDLE. With macro, model never asserts done -> OUT_TIMEOUT=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/divider_adapter_pkg.sv
// Shared types for the divider stream adapter: FSM state encoding and the
// most-negative-word helper used for the MIN/-1 overflow check.
package divider_adapter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIX,
    ST_OUT
  } adapter_state_t;

  // Most negative two's-complement value of a word of the given width (width <= 64).
  function automatic logic [63:0] word_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/divider_sign_fix.sv
// Combinational one-step quotient/remainder correction so the remainder takes the
// numerator's sign (or is zero). Requires |r| < |den| from the upstream divider.
module divider_sign_fix #(
  parameter int WORD_WIDTH = 8
) (
  input  logic [WORD_WIDTH-1:0] num,
  input  logic [WORD_WIDTH-1:0] den,
  input  logic [WORD_WIDTH-1:0] q,
  input  logic [WORD_WIDTH-1:0] r,
  output logic [WORD_WIDTH-1:0] q_fixed,
  output logic [WORD_WIDTH-1:0] r_fixed
);

  logic needs_fix;

  always_comb begin
    q_fixed   = q;
    r_fixed   = r;
    needs_fix = (r != '0) && (r[WORD_WIDTH-1] != num[WORD_WIDTH-1]);
    if (needs_fix) begin
      if (r[WORD_WIDTH-1] != den[WORD_WIDTH-1]) begin
        r_fixed = r + den;
        q_fixed = q - WORD_WIDTH'(1);
      end else begin
        r_fixed = r - den;
        q_fixed = q + WORD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/divider_stream_adapter.sv
// Valid/ready front-end for divider_nonrestoring_signed with truncation-style result
// normalisation and divide-by-zero / MIN/-1 short-circuits. Watchdog: DIV_ADAPTER_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; short-circuit cases go straight to OUT
// ST_ISSUE | DIV_START pulse with operands held on DIV_NUM_OUT/DIV_DEN_OUT
// ST_WAIT  | waiting for a DIV_DONE rising edge (or watchdog expiry)
// ST_FIX   | sign correction of the captured quotient/remainder
// ST_OUT   | result presented until OUT_READY
module divider_stream_adapter
  import divider_adapter_pkg::*;
#(
  parameter int WORD_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4*WORD_WIDTH+8
) (
  input  logic                  CLK,
  input  logic                  ARST,
  input  logic                  CE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WORD_WIDTH-1:0] IN_NUM,
  input  logic [WORD_WIDTH-1:0] IN_DEN,
  output logic [WORD_WIDTH-1:0] DIV_NUM_OUT,
  output logic [WORD_WIDTH-1:0] DIV_DEN_OUT,
  output logic                  DIV_START,
  input  logic [WORD_WIDTH-1:0] DIV_QUOT_IN,
  input  logic [WORD_WIDTH-1:0] DIV_REM_IN,
  input  logic                  DIV_DONE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [WORD_WIDTH-1:0] OUT_QUOT,
  output logic [WORD_WIDTH-1:0] OUT_REM,
  output logic                  OUT_DIVZERO,
  output logic                  OUT_OVF,
  output logic                  OUT_TIMEOUT,
  output logic                  BUSY
);

  localparam logic [WORD_WIDTH-1:0] MIN_VAL = WORD_WIDTH'(word_min(WORD_WIDTH));

  adapter_state_t        state, state_nxt;
  logic [WORD_WIDTH-1:0] num_r, num_nxt, den_r, den_nxt;
  logic [WORD_WIDTH-1:0] q_cap, q_cap_nxt, r_cap, r_cap_nxt;
  logic [WORD_WIDTH-1:0] quot_r, quot_nxt, rem_r, rem_nxt;
  logic [WORD_WIDTH-1:0] q_fixed, r_fixed;
  logic                  start_r, start_nxt;
  logic                  out_valid_r, out_valid_nxt;
  logic                  divzero_r, divzero_nxt, ovf_r, ovf_nxt, tmo_r, tmo_nxt;
  logic                  busy_r;
  logic                  done_prev;
  logic                  done_edge;
  logic                  in_fire;

`ifdef DIV_ADAPTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] wait_cnt, wait_cnt_nxt;
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES != 0);
`endif

  assign IN_READY  = (state == ST_IDLE) & CE;
  assign in_fire   = IN_VALID & IN_READY;
  // done_prev follows DIV_DONE in every enabled cycle, so a held level never looks like an edge
  assign done_edge = DIV_DONE & ~done_prev;

  divider_sign_fix #(.WORD_WIDTH(WORD_WIDTH)) u_sign_fix (
    .num     (num_r),
    .den     (den_r),
    .q       (q_cap),
    .r       (r_cap),
    .q_fixed (q_fixed),
    .r_fixed (r_fixed)
  );

  always_comb begin
    state_nxt     = state;
    num_nxt       = num_r;
    den_nxt       = den_r;
    q_cap_nxt     = q_cap;
    r_cap_nxt     = r_cap;
    quot_nxt      = quot_r;
    rem_nxt       = rem_r;
    start_nxt     = 1'b0;
    out_valid_nxt = out_valid_r;
    divzero_nxt   = divzero_r;
    ovf_nxt       = ovf_r;
    tmo_nxt       = tmo_r;
`ifdef DIV_ADAPTER_TIMEOUT_EN
    wait_cnt_nxt  = wait_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          if (IN_DEN == '0) begin
            state_nxt     = ST_OUT;
            out_valid_nxt = 1'b1;
            quot_nxt      = '0;
            rem_nxt       = IN_NUM;
            divzero_nxt   = 1'b1;
          end else if ((IN_NUM == MIN_VAL) && (IN_DEN == '1)) begin
            state_nxt     = ST_OUT;
            out_valid_nxt = 1'b1;
            quot_nxt      = MIN_VAL;
            rem_nxt       = '0;
            ovf_nxt       = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
            num_nxt   = IN_NUM;
            den_nxt   = IN_DEN;
            start_nxt = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
`ifdef DIV_ADAPTER_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      ST_WAIT: begin
        if (done_edge) begin
          state_nxt = ST_FIX;
          q_cap_nxt = DIV_QUOT_IN;
          r_cap_nxt = DIV_REM_IN;
        end
`ifdef DIV_ADAPTER_TIMEOUT_EN
        else begin
          wait_cnt_nxt = wait_cnt + TMO_W'(1);
          if (wait_cnt_nxt == TMO_W'(TIMEOUT_CYCLES)) begin
            state_nxt     = ST_OUT;
            out_valid_nxt = 1'b1;
            quot_nxt      = '0;
            rem_nxt       = '0;
            tmo_nxt       = 1'b1;
          end
        end
`endif
      end
      ST_FIX: begin
        state_nxt     = ST_OUT;
        out_valid_nxt = 1'b1;
        quot_nxt      = q_fixed;
        rem_nxt       = r_fixed;
      end
      ST_OUT: begin
        if (OUT_READY) begin
          state_nxt     = ST_IDLE;
          out_valid_nxt = 1'b0;
          divzero_nxt   = 1'b0;
          ovf_nxt       = 1'b0;
          tmo_nxt       = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state       <= ST_IDLE;
      num_r       <= '0;
      den_r       <= '0;
      q_cap       <= '0;
      r_cap       <= '0;
      quot_r      <= '0;
      rem_r       <= '0;
      start_r     <= 1'b0;
      out_valid_r <= 1'b0;
      divzero_r   <= 1'b0;
      ovf_r       <= 1'b0;
      tmo_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_prev   <= 1'b0;
`ifdef DIV_ADAPTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else if (CE) begin
      state       <= state_nxt;
      num_r       <= num_nxt;
      den_r       <= den_nxt;
      q_cap       <= q_cap_nxt;
      r_cap       <= r_cap_nxt;
      quot_r      <= quot_nxt;
      rem_r       <= rem_nxt;
      start_r     <= start_nxt;
      out_valid_r <= out_valid_nxt;
      divzero_r   <= divzero_nxt;
      ovf_r       <= ovf_nxt;
      tmo_r       <= tmo_nxt;
      busy_r      <= (state_nxt != ST_IDLE);
      done_prev   <= DIV_DONE;
`ifdef DIV_ADAPTER_TIMEOUT_EN
      wait_cnt    <= wait_cnt_nxt;
`endif
    end
  end

  assign DIV_NUM_OUT = num_r;
  assign DIV_DEN_OUT = den_r;
  assign DIV_START   = start_r;
  assign OUT_VALID   = out_valid_r;
  assign OUT_QUOT    = quot_r;
  assign OUT_REM     = rem_r;
  assign OUT_DIVZERO = divzero_r;
  assign OUT_OVF     = ovf_r;
  assign OUT_TIMEOUT = tmo_r;
  assign BUSY        = busy_r;

endmodule

// File: tb/tb_divider_stream_adapter.sv
// Directed bench for divider_stream_adapter; the bench plays the divider by driving
// quotient/remainder/done by hand. Timeout case only built with DIV_ADAPTER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_divider_stream_adapter;

  logic       tb_clk = 1'b0;
  logic       tb_srst = 1'b1;
  logic       ce = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_num = '0, in_den = '0;
  logic [7:0] div_num, div_den;
  logic       div_start;
  logic [7:0] div_quot = '0, div_rem = '0;
  logic       div_done = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_quot, out_rem;
  logic       out_divzero, out_ovf, out_timeout, busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int start_cnt = 0;

  divider_stream_adapter #(.WORD_WIDTH(8)) dut (
    .CLK         (tb_clk),
    .ARST        (tb_srst),
    .CE          (ce),
    .IN_VALID    (in_valid),
    .IN_READY    (in_ready),
    .IN_NUM      (in_num),
    .IN_DEN      (in_den),
    .DIV_NUM_OUT (div_num),
    .DIV_DEN_OUT (div_den),
    .DIV_START   (div_start),
    .DIV_QUOT_IN (div_quot),
    .DIV_REM_IN  (div_rem),
    .DIV_DONE    (div_done),
    .OUT_VALID   (out_valid),
    .OUT_READY   (out_ready),
    .OUT_QUOT    (out_quot),
    .OUT_REM     (out_rem),
    .OUT_DIVZERO (out_divzero),
    .OUT_OVF     (out_ovf),
    .OUT_TIMEOUT (out_timeout),
    .BUSY        (busy)
  );

  always #5 tb_clk = ~tb_clk;

  always @(negedge tb_clk) if (div_start) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ":ack_valid"}, out_valid, 0);
    chk({tag, ":ack_flags"}, {out_divzero, out_ovf, out_timeout}, 0);
    chk({tag, ":ack_busy"}, busy, 0);
  endtask

  // Normal path: mq/mr are what the divider returns, eq/er the normalised result.
  task automatic run_div(input string tag, input logic [7:0] num, input logic [7:0] den,
                         input logic [7:0] mq, input logic [7:0] mr,
                         input logic [7:0] eq, input logic [7:0] er, input bit do_ack);
    int s0;
    s0 = start_cnt;
    in_valid = 1'b1; in_num = num; in_den = den;
    chk({tag, ":in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, ":start"}, div_start, 1);
    chk({tag, ":div_ops"}, {div_num, div_den}, {num, den});
    chk({tag, ":busy"}, busy, 1);
    step();
    chk({tag, ":start_end"}, div_start, 0);
    div_quot = mq; div_rem = mr; div_done = 1'b1;
    step();
    div_done = 1'b0;
    chk({tag, ":valid_early"}, out_valid, 0);
    step();
    chk({tag, ":valid"}, out_valid, 1);
    chk({tag, ":quot"}, out_quot, eq);
    chk({tag, ":rem"}, out_rem, er);
    chk({tag, ":flags"}, {out_divzero, out_ovf, out_timeout}, 0);
    chk({tag, ":start_count"}, start_cnt - s0, 1);
    if (do_ack) ack(tag);
  endtask

  initial begin
    int s0;
    // reset: IN_READY follows CE, everything else quiet
    #1;
    chk("rst_ready_ce0", in_ready, 0);
    ce = 1'b1;
    #1;
    chk("rst_ready_ce1", in_ready, 1);
    chk("rst_outs", {out_valid, div_start, busy, out_quot, out_rem, div_num, div_den}, 0);
    step();
    tb_srst = 1'b0;
    step();

    run_div("7div2",   8'd7,   8'd2,   8'd4,   8'hFF, 8'd3,   8'd1,   1'b1);
    run_div("7divm2",  8'd7,   8'hFE,  8'hFC,  8'hFF, 8'hFD,  8'd1,   1'b1);
    run_div("m7div2",  8'hF9,  8'd2,   8'hFD,  8'hFF, 8'hFD,  8'hFF,  1'b1);
    run_div("m7divm2", 8'hF9,  8'hFE,  8'd4,   8'd1,  8'd3,   8'hFF,  1'b1);

    // divide by zero
    s0 = start_cnt;
    in_valid = 1'b1; in_num = 8'd5; in_den = 8'd0;
    step();
    in_valid = 1'b0;
    chk("dz:valid", out_valid, 1);
    chk("dz:qr", {out_quot, out_rem}, {8'd0, 8'd5});
    chk("dz:flags", {out_divzero, out_ovf}, 2'b10);
    chk("dz:no_start", start_cnt - s0, 0);
    ack("dz");

    // MIN / -1
    s0 = start_cnt;
    in_valid = 1'b1; in_num = 8'h80; in_den = 8'hFF;
    step();
    in_valid = 1'b0;
    chk("ovf:valid", out_valid, 1);
    chk("ovf:qr", {out_quot, out_rem}, {8'h80, 8'd0});
    chk("ovf:flags", {out_divzero, out_ovf}, 2'b01);
    chk("ovf:no_start", start_cnt - s0, 0);
    ack("ovf");

    // leftover DONE level must not complete the op; only the later rising edge does
    s0 = start_cnt;
    div_done = 1'b1; div_quot = 8'hFC; div_rem = 8'hFF;
    in_valid = 1'b1; in_num = 8'd7; in_den = 8'hFE;
    step();
    in_valid = 1'b0;
    step();
    step();
    div_done = 1'b0;
    chk("held:valid0", out_valid, 0);
    step();
    chk("held:valid1", out_valid, 0);
    step();
    step();
    chk("held:busy", {busy, out_valid}, 2'b10);
    div_done = 1'b1;
    step();
    div_done = 1'b0;
    chk("held:valid_fix", out_valid, 0);
    step();
    chk("held:valid", out_valid, 1);
    chk("held:qr", {out_quot, out_rem}, {8'hFD, 8'd1});
    chk("held:start_count", start_cnt - s0, 1);
    ack("held");

    // backpressure: result held, no new request accepted until handshake
    run_div("bp", 8'hF9, 8'd2, 8'hFD, 8'hFF, 8'hFD, 8'hFF, 1'b0);
    in_valid = 1'b1; in_num = 8'd5; in_den = 8'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp:in_ready", in_ready, 0);
      chk("bp:hold", {out_valid, out_quot, out_rem, out_divzero}, {1'b1, 8'hFD, 8'hFF, 1'b0});
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp:released", {in_ready, out_valid}, 2'b10);
    step();
    in_valid = 1'b0;
    chk("bp:second", {out_valid, out_quot, out_rem, out_divzero}, {1'b1, 8'd0, 8'd5, 1'b1});
    ack("bp2");

    // CE low for 3 cycles mid-WAIT stretches latency by 3
    in_valid = 1'b1; in_num = 8'd7; in_den = 8'd2;
    step();
    in_valid = 1'b0;
    step();
    ce = 1'b0;
    div_quot = 8'd4; div_rem = 8'hFF; div_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ce:frozen", {busy, out_valid, in_ready, div_start}, 4'b1000);
    end
    ce = 1'b1;
    step();
    chk("ce:valid_fix", out_valid, 0);
    step();
    div_done = 1'b0;
    chk("ce:valid", out_valid, 1);
    chk("ce:qr", {out_quot, out_rem}, {8'd3, 8'd1});
    ack("ce");

    // async reset in WAIT, later done edge ignored
    in_valid = 1'b1; in_num = 8'd9; in_den = 8'd4;
    step();
    in_valid = 1'b0;
    step();
    #2;
    tb_srst = 1'b1;
    #1;
    chk("arst:outs", {out_valid, div_start, busy, out_quot, out_rem, div_num, div_den}, 0);
    chk("arst:in_ready", in_ready, 1);
    step();
    tb_srst = 1'b0;
    div_quot = 8'd2; div_rem = 8'd1; div_done = 1'b1;
    step();
    step();
    div_done = 1'b0;
    chk("arst:idle", {busy, out_valid}, 0);

`ifdef DIV_ADAPTER_TIMEOUT_EN
    begin
      int n;
      n = 0;
      in_valid = 1'b1; in_num = 8'd7; in_den = 8'd2;
      step();
      in_valid = 1'b0;
      while (!out_valid && n < 100) begin
        step();
        n++;
      end
      chk("tmo:reached", out_valid, 1);
      chk("tmo:cycles", n, 41);
      chk("tmo:result", {out_timeout, out_quot, out_rem}, {1'b1, 8'd0, 8'd0});
      ack("tmo");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
